fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer between the IF stage and the instruction bus.
- Issues one ibus request at a time for the current fetch PC and holds the returned word until the decode stage accepts it.
- Raises a fetch-stall request to the hazard unit while no instruction is available.
- Handles redirects with an outstanding request by discarding the stale response, since an accepted request cannot be withdrawn.

Parameters:
- RESET_PC, 32'hbfc0_0000, value driven on ireq.addr while no fetch address has been captured (debug visibility only).

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- PCF  in  32  fetch PC from the F-stage register; stable while IStall=1 unless redirect=1
- StallD  in  1  decode stage stalled; held instruction must not be consumed
- redirect  in  1  current fetch is wrong-path; PCF carries the new target from the next cycle
- ireq  out  ibus_req_t  {valid, addr}
- iresp  in  ibus_resp_t  {addr_ok, data_ok, data[31:0]}
- instr  out  32  instruction word for the F/D register
- instr_valid  out  1  instr belongs to PCF and may be latched
- IStall  out  1  fetch not ready; the hazard unit stalls F and bubbles D

Behaviour:
- States: S_IDLE, S_ADDR (valid asserted, awaiting addr_ok), S_DATA (accepted, awaiting data_ok), S_HOLD (word buffered).
- Registers: state, addr_q, req_held, instr_q, discard.
- Reset (resetn=0 at posedge):
  - state=S_IDLE; req_held, discard, instr_q all 0; addr_q=RESET_PC.
  - Outputs while in S_IDLE: ireq.valid=0, instr_valid=0, IStall=1.
- S_IDLE: unconditionally moves to S_ADDR next cycle.
- S_ADDR: ireq.valid=1; ireq.addr = req_held ? addr_q : PCF.
  - addr_ok=0: addr_q<=ireq.addr and req_held<=1. Address and valid stay stable until accepted, even across a redirect.
  - addr_ok=1, data_ok=0: go to S_DATA; req_held<=0.
  - addr_ok=1 and data_ok=1 in the same cycle: treated as an immediate completion with the S_DATA rules below.
- S_DATA: ireq.valid=0. On data_ok:
  - discard=1: drop data, discard<=0, go to S_ADDR (new PCF).
  - Else: instr_q<=data. Go to S_HOLD if StallD=1, or to S_ADDR if StallD=0 (word consumed this cycle via bypass).
- Bypass: in the data_ok cycle with discard=0, instr=iresp.data, instr_valid=1, IStall=0. Zero-bubble path.
- S_HOLD: instr=instr_q, instr_valid=1, IStall=0. Go to S_ADDR when StallD=0; stay while StallD=1.
- IStall = ~instr_valid in every state.
- Redirect handling:
  - S_HOLD: drop buffer, go to S_ADDR.
  - S_ADDR with addr_ok=0 and request already held or issued: discard<=1. The request completes, then S_ADDR refetches.
  - S_ADDR with addr_ok=1, or S_DATA: discard<=1.
  - A redirect coinciding with data_ok: data is dropped, go to S_ADDR, discard<=0.
  - S_IDLE: no effect.
  - While discard=1: instr_valid=0, IStall=1.
- At most one outstanding request; ireq.valid is never asserted in S_DATA.
- Reset mid-transaction: all state is cleared. A data_ok arriving in the first cycles after reset is ignored (S_IDLE/S_ADDR ignore data_ok unless addr_ok is accepted in that same cycle).

Decomposition:
- Shared package: fetch_state_t enum (S_IDLE, S_ADDR, S_DATA, S_HOLD) and the RESET_PC constant, alongside the existing ibus_req_t / ibus_resp_t.
- No sub-module; a single FSM plus buffer registers.

Test Plan:
- Reset then PCF=32'hbfc0_0000, addr_ok=1 on first valid, data_ok=1 two cycles later with data=32'h2408_0001 -> instr valid in the data_ok cycle, IStall=0 for exactly that cycle, next request issued the following cycle.
- addr_ok held low 3 cycles while PCF changes via redirect -> ireq.addr stays 32'hbfc0_0000 all 3 cycles; after data_ok, the old word is dropped and a new request to the redirected PCF=32'hbfc0_0100 is issued.
- addr_ok and data_ok in the same cycle with StallD=0 -> single-cycle fetch, instr_valid=1 that cycle, back to S_ADDR.
- data_ok with StallD=1 for 4 cycles -> S_HOLD; instr_q stable; ireq.valid=0 throughout; on StallD=0, new request issued next cycle.
- Redirect asserted in S_DATA, then data_ok -> instr_valid stays 0 and IStall=1 until the refetched word returns.
- resetn=0 asserted while in S_DATA, with data_ok arriving in the next cycle -> state S_IDLE, IStall=1, ireq.valid=0, no instr_valid pulse.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared instruction-bus and fetch sequencer types.
// Imported by the fetch controller and its bench.
package fetch_ctrl_pkg;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_HOLD
  } fetch_state_t;

  localparam logic [31:0] RESET_PC = 32'hbfc0_0000;

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: one outstanding ibus request,
// zero-bubble bypass, hold buffer and stale-response discard.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = fetch_ctrl_pkg::RESET_PC
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] PCF,
  input  logic        StallD,
  input  logic        redirect,
  output ibus_req_t   ireq,
  input  ibus_resp_t  iresp,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        IStall
);

  fetch_state_t state, stateNext;
  logic [31:0]  addrQ, addrNext;
  logic [31:0]  instrQ, instrNext;
  logic         reqHeld, heldNext;
  logic         discard, discardNext;
  logic         done;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= S_IDLE;
      addrQ   <= RESET_PC;
      instrQ  <= '0;
      reqHeld <= 1'b0;
      discard <= 1'b0;
    end else begin
      state   <= stateNext;
      addrQ   <= addrNext;
      instrQ  <= instrNext;
      reqHeld <= heldNext;
      discard <= discardNext;
    end
  end

  always_comb begin
    stateNext   = state;
    addrNext    = addrQ;
    instrNext   = instrQ;
    heldNext    = reqHeld;
    discardNext = discard;
    done        = 1'b0;
    instr_valid = 1'b0;
    ireq.valid  = 1'b0;
    ireq.addr   = (state == S_ADDR && !reqHeld)
                ? PCF : addrQ;
    instr       = (state == S_HOLD)
                ? instrQ : iresp.data;

    unique case (state)
      S_IDLE: stateNext = S_ADDR;
      S_ADDR: begin
        ireq.valid = 1'b1;
        if (!iresp.addr_ok) begin
          // Keep the offered request stable until accepted.
          addrNext = ireq.addr;
          heldNext = 1'b1;
          if (redirect) discardNext = 1'b1;
        end else begin
          heldNext = 1'b0;
          if (iresp.data_ok) begin
            done = 1'b1;
          end else begin
            stateNext = S_DATA;
            if (redirect) discardNext = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (iresp.data_ok) done = 1'b1;
        else if (redirect) discardNext = 1'b1;
      end
      S_HOLD: begin
        instr_valid = !redirect;
        if (redirect || !StallD) stateNext = S_ADDR;
      end
      default: stateNext = S_IDLE;
    endcase

    // Response arrival: deliver or drop a wrong-path word.
    if (done) begin
      discardNext = 1'b0;
      stateNext   = S_ADDR;
      if (!discard && !redirect) begin
        instr_valid = 1'b1;
        instrNext   = iresp.data;
        if (StallD) stateNext = S_HOLD;
      end
    end

    IStall = ~instr_valid;
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed vector bench for the fetch sequencer.
// One row per cycle plus hand-written corner sequences.
module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] PCF;
  logic        StallD;
  logic        redirect;
  ibus_req_t   ireq;
  ibus_resp_t  iresp;
  logic [31:0] instr;
  logic        instr_valid;
  logic        IStall;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk        (clk),
    .resetn     (resetn),
    .PCF        (PCF),
    .StallD     (StallD),
    .redirect   (redirect),
    .ireq       (ireq),
    .iresp      (iresp),
    .instr      (instr),
    .instr_valid(instr_valid),
    .IStall     (IStall)
  );

  typedef struct {
    logic        rn;
    logic [31:0] pc;
    logic        st;
    logic        rd;
    logic        aok;
    logic        dok;
    logic [31:0] d;
    logic        ev;
    logic [31:0] ea;
    logic        eiv;
    logic [31:0] ei;
  } vec_t;

  vec_t vq[$];
  int   nCmp = 0;
  int   nBad = 0;

  task automatic cmp(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rn, input logic [31:0] pc,
                       input logic st, input logic rd,
                       input logic aok, input logic dok,
                       input logic [31:0] d);
    @(negedge clk);
    resetn        = rn;
    PCF           = pc;
    StallD        = st;
    redirect      = rd;
    iresp.addr_ok = aok;
    iresp.data_ok = dok;
    iresp.data    = d;
    #1;
  endtask

  task automatic expectOut(input string tag, input logic ev,
                           input logic [31:0] ea, input logic eiv,
                           input logic [31:0] ei);
    cmp({tag, ".valid"}, 32'(ireq.valid), 32'(ev));
    if (ev) cmp({tag, ".addr"}, ireq.addr, ea);
    cmp({tag, ".instr_valid"}, 32'(instr_valid), 32'(eiv));
    cmp({tag, ".IStall"}, 32'(IStall), 32'(!eiv));
    if (eiv) cmp({tag, ".instr"}, instr, ei);
  endtask

  task automatic add(input logic rn, input logic [31:0] pc,
                     input logic st, input logic rd,
                     input logic aok, input logic dok,
                     input logic [31:0] d, input logic ev,
                     input logic [31:0] ea, input logic eiv,
                     input logic [31:0] ei);
    vec_t v;
    v = '{rn, pc, st, rd, aok, dok, d, ev, ea, eiv, ei};
    vq.push_back(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int w;
    // Basic fetch: accept, one wait, data
    add(1, 32'hbfc00000, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 32'hbfc00000, 0, 0, 1, 0, 0, 1, 32'hbfc00000, 0, 0);
    add(1, 32'hbfc00000, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 32'hbfc00000, 0, 0, 0, 1, 32'h24080001,
        0, 0, 1, 32'h24080001);
    // addr_ok low 3 cycles across redirect
    add(1, 32'hbfc00000, 0, 1, 0, 0, 0, 1, 32'hbfc00000, 0, 0);
    add(1, 32'hbfc00100, 0, 0, 0, 0, 0, 1, 32'hbfc00000, 0, 0);
    add(1, 32'hbfc00100, 0, 0, 0, 0, 0, 1, 32'hbfc00000, 0, 0);
    add(1, 32'hbfc00100, 0, 0, 1, 0, 0, 1, 32'hbfc00000, 0, 0);
    add(1, 32'hbfc00100, 0, 0, 0, 1, 32'hdeadbeef, 0, 0, 0, 0);
    // Same-cycle addr_ok/data_ok to the redirected PC
    add(1, 32'hbfc00100, 0, 0, 1, 1, 32'h00000013,
        1, 32'hbfc00100, 1, 32'h00000013);
    // StallD hold for 4 cycles
    add(1, 32'hbfc00104, 0, 0, 1, 0, 0, 1, 32'hbfc00104, 0, 0);
    add(1, 32'hbfc00104, 1, 0, 0, 1, 32'h8c220004,
        0, 0, 1, 32'h8c220004);
    add(1, 32'hbfc00104, 1, 0, 0, 0, 0, 0, 0, 1, 32'h8c220004);
    add(1, 32'hbfc00104, 1, 0, 0, 0, 0, 0, 0, 1, 32'h8c220004);
    add(1, 32'hbfc00104, 1, 0, 0, 0, 0, 0, 0, 1, 32'h8c220004);
    add(1, 32'hbfc00104, 0, 0, 0, 0, 0, 0, 0, 1, 32'h8c220004);
    add(1, 32'hbfc00108, 0, 0, 0, 0, 0, 1, 32'hbfc00108, 0, 0);
    add(1, 32'hbfc00108, 0, 0, 1, 0, 0, 1, 32'hbfc00108, 0, 0);
    add(1, 32'hbfc00108, 0, 0, 0, 1, 32'haaaa0001,
        0, 0, 1, 32'haaaa0001);

    drive(0, 32'hbfc00000, 0, 0, 0, 0, 0);
    drive(0, 32'hbfc00000, 0, 0, 0, 0, 0);
    foreach (vq[i]) begin
      drive(vq[i].rn, vq[i].pc, vq[i].st, vq[i].rd,
            vq[i].aok, vq[i].dok, vq[i].d);
      expectOut($sformatf("v%0d", i), vq[i].ev, vq[i].ea,
                vq[i].eiv, vq[i].ei);
    end

    // Redirect while in S_DATA, stale word dropped, refetch
    drive(1, 32'hbfc00200, 0, 0, 1, 0, 0);
    expectOut("rd.issue", 1, 32'hbfc00200, 0, 0);
    drive(1, 32'hbfc00200, 0, 1, 0, 0, 0);
    expectOut("rd.redir", 0, 0, 0, 0);
    drive(1, 32'hbfc00300, 0, 0, 0, 0, 0);
    expectOut("rd.wait1", 0, 0, 0, 0);
    drive(1, 32'hbfc00300, 0, 0, 0, 0, 0);
    expectOut("rd.wait2", 0, 0, 0, 0);
    drive(1, 32'hbfc00300, 0, 0, 0, 1, 32'hbadbad00);
    expectOut("rd.stale", 0, 0, 0, 0);
    w = 0;
    drive(1, 32'hbfc00300, 0, 0, 0, 0, 0);
    while (!ireq.valid && w < 8) begin
      drive(1, 32'hbfc00300, 0, 0, 0, 0, 0);
      w++;
    end
    cmp("rd.refetch_wait", 32'(ireq.valid), 32'd1);
    drive(1, 32'hbfc00300, 0, 0, 1, 0, 0);
    expectOut("rd.reissue", 1, 32'hbfc00300, 0, 0);
    drive(1, 32'hbfc00300, 0, 0, 0, 1, 32'h3c011234);
    expectOut("rd.data", 0, 0, 1, 32'h3c011234);

    // Reset while in S_DATA, data_ok just after reset
    drive(1, 32'hbfc00400, 0, 0, 1, 0, 0);
    expectOut("rst.issue", 1, 32'hbfc00400, 0, 0);
    drive(0, 32'hbfc00400, 0, 0, 0, 0, 0);
    expectOut("rst.assert", 0, 0, 0, 0);
    drive(1, 32'hbfc00400, 0, 0, 0, 1, 32'hffffffff);
    expectOut("rst.idle", 0, 0, 0, 0);
    drive(1, 32'hbfc00400, 0, 0, 0, 1, 32'hffffffff);
    expectOut("rst.addr", 1, 32'hbfc00400, 0, 0);
    drive(1, 32'hbfc00400, 0, 0, 1, 0, 0);
    expectOut("rst.accept", 1, 32'hbfc00400, 0, 0);
    drive(1, 32'hbfc00400, 0, 0, 0, 1, 32'h11112222);
    expectOut("rst.data", 0, 0, 1, 32'h11112222);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             nCmp, nBad);
    $finish;
  end

endmodule
